// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART telemetry packet framer.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } framer_state_t;

    // Width of an index counting 0..n-1, never less than one bit.
    function automatic int byte_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word input stream and transmitter byte handshake of the packet framer.
interface uart_tx_framer_if #(
    parameter int WORD_W = 16
);
    import uart_frame_pkg::*;

    // Word side: a word transfers on a clock edge where word_valid_i && word_ready_o;
    // transmitter side: tx_start_o holds with tx_data_o until tx_busy_i is seen high,
    // and tx_data_o then stays put until tx_busy_i falls.
    logic              word_valid_i;
    logic [WORD_W-1:0] word_i;
    logic              word_ready_o;
    logic              overflow_o;
    logic              tx_start_o;
    logic [7:0]        tx_data_o;
    logic              tx_busy_i;
    logic              frame_busy_o;
    framer_state_t     fsm_state;

    modport master (
        output word_valid_i, word_i, tx_busy_i,
        input  word_ready_o, overflow_o, tx_start_o, tx_data_o, frame_busy_o, fsm_state
    );

    modport slave (
        input  word_valid_i, word_i, tx_busy_i,
        output word_ready_o, overflow_o, tx_start_o, tx_data_o, frame_busy_o, fsm_state
    );

endinterface

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with occupancy count; pushes when full and pops when empty are ignored.
module uart_word_fifo #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WORD_W-1:0]             data_in,
    input  logic                          pop,
    output logic [WORD_W-1:0]             head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Packs groups of telemetry words into SYNC/SEQ/payload/CSUM frames and feeds them
// one byte at a time into a UART transmitter's start/busy handshake.
module uart_tx_framer
    import uart_frame_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int N_WORDS    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    uart_tx_framer_if.slave  bus
);
    localparam int BPW       = WORD_W / 8;
    localparam int FRAME_LEN = N_WORDS * BPW + 3;
    localparam int PW        = byte_idx_w(FRAME_LEN);
    localparam int SW        = byte_idx_w(BPW);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] POS_CSUM  = PW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SEL_LAST  = SW'(BPW - 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(N_WORDS);

    framer_state_t     state, state_n;
    logic [7:0]        tx_data;
    logic [PW-1:0]     pos, pos_n, pos_inc;
    logic [SW-1:0]     byte_sel, sel_n;
    logic [7:0]        csum;
    logic [7:0]        seq;
    logic              overflow;

    logic              load;
    logic [7:0]        next_byte;
    logic              csum_add;
    logic              csum_clr;
    logic              seq_inc;
    logic              pop_req;

    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] head_shift;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              word_ready;

    uart_word_fifo #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .reset  (reset_i),
        .push   (bus.word_valid_i),
        .data_in(bus.word_i),
        .pop    (pop_req && !fifo_empty),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign word_ready = !fifo_full;
    // Payload bytes come from the FIFO head, MSB byte first; the word leaves with its last byte.
    assign head_shift = fifo_head << {byte_sel, 3'b000};
    assign pos_inc    = pos + 1'b1;

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        sel_n     = byte_sel;
        load      = 1'b0;
        next_byte = tx_data;
        csum_add  = 1'b0;
        csum_clr  = 1'b0;
        seq_inc   = 1'b0;
        pop_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_count >= FRAME_CNT) begin
                    state_n   = ST_REQ;
                    load      = 1'b1;
                    next_byte = SYNC_BYTE;
                    pos_n     = '0;
                    sel_n     = '0;
                    csum_clr  = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.tx_busy_i) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.tx_busy_i) begin
                    if (pos == POS_CSUM) begin
                        state_n = ST_IDLE;
                        seq_inc = 1'b1;
                    end else begin
                        state_n = ST_REQ;
                        load    = 1'b1;
                        pos_n   = pos_inc;
                        if (pos == '0) begin
                            next_byte = seq;
                            csum_add  = 1'b1;
                        end else if (pos_inc == POS_CSUM) begin
                            next_byte = csum;
                        end else begin
                            next_byte = head_shift[WORD_W-1 -: 8];
                            csum_add  = 1'b1;
                            if (byte_sel == SEL_LAST) begin
                                pop_req = 1'b1;
                                sel_n   = '0;
                            end else begin
                                sel_n = byte_sel + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            tx_data  <= 8'h00;
            pos      <= '0;
            byte_sel <= '0;
            csum     <= 8'h00;
            seq      <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            byte_sel <= sel_n;
            if (load) tx_data <= next_byte;
            if (csum_clr) begin
                csum <= 8'h00;
            end else if (csum_add) begin
                csum <= csum + next_byte;
            end
            if (seq_inc) seq <= seq + 8'd1;
            if (bus.word_valid_i && !word_ready) overflow <= 1'b1;
        end
    end

    assign bus.word_ready_o = word_ready;
    assign bus.overflow_o   = overflow;
    assign bus.tx_start_o   = (state == ST_REQ);
    assign bus.tx_data_o    = tx_data;
    assign bus.frame_busy_o = (state != ST_IDLE);
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer driving a behavioural UART transmitter model.
module tb_uart_tx_framer;
  import uart_frame_pkg::*;

  localparam int BIT_CYC  = 1;
  localparam int BUSY_CYC = 10 * BIT_CYC;
  localparam int TIMEOUT  = 3000;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  seq;
    logic [7:0]  csum;
  } frame_vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_framer_if #(.WORD_W(16)) bus();

  uart_tx_framer #(
    .WORD_W    (16),
    .N_WORDS   (2),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  // transmitter model state and scoreboard
  logic       busy = 1'b0;
  logic       pend = 1'b0;
  logic       tx_hold = 1'b0;
  int         cnt = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         stab_err = 0;
  int         since_fall = -1;
  int         max_gap = 0;
  int         n_vec = 0;
  int         n_err = 0;

  assign bus.tx_busy_i = busy;

  // Busy rises one cycle after a start is taken and lasts ten bit periods.
  always @(negedge clk) begin
    if (reset) begin
      busy = 1'b0;
      pend = 1'b0;
      cnt = 0;
      since_fall = -1;
    end else begin
      if (since_fall >= 0) since_fall++;
      if (busy) begin
        if (bus.tx_data_o !== cur) stab_err++;
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          since_fall = 0;
        end
      end else if (pend) begin
        if (bus.tx_data_o !== cur) stab_err++;
        busy = 1'b1;
        cnt = BUSY_CYC;
        pend = 1'b0;
      end else if (bus.tx_start_o === 1'b1 && !tx_hold) begin
        pend = 1'b1;
        cur = bus.tx_data_o;
        rx_q.push_back(cur);
        if (since_fall >= 0 && cur != SYNC_BYTE && since_fall > max_gap) max_gap = since_fall;
        since_fall = -1;
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.word_valid_i = 1'b1;
    bus.word_i = w;
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.word_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete();
  endtask

  task automatic wait_bytes(input int n, input string name);
    bit done = 1'b0;
    for (int i = 0; i < TIMEOUT && !done; i++) begin
      @(negedge clk);
      done = (rx_q.size() >= n) && (bus.frame_busy_o == 1'b0);
    end
    @(posedge clk); #1;
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  function automatic logic [7:0] calc_csum(input logic [7:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [7:0] sum;
    sum = s;
    sum = sum + a[15:8];
    sum = sum + a[7:0];
    sum = sum + b[15:8];
    sum = sum + b[7:0];
    return sum;
  endfunction

  task automatic expect_frame(input string name, input logic [7:0] seq, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [7:0] csum);
    logic [7:0] got;
    logic [7:0] exp_b;
    exp_q.push_back(SYNC_BYTE);
    exp_q.push_back(seq);
    exp_q.push_back(w0[15:8]);
    exp_q.push_back(w0[7:0]);
    exp_q.push_back(w1[15:8]);
    exp_q.push_back(w1[7:0]);
    exp_q.push_back(csum);
    for (int i = 0; i < 7; i++) begin
      exp_b = exp_q.pop_front();
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("%s_b%0d", name, i), 32'(got), 32'(exp_b));
    end
  endtask

  frame_vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_bad;
    bit seen;
    logic [15:0] a;
    logic [15:0] b;

    vecs[0] = '{16'h1234, 16'hABCD, 8'h00, 8'hBE};
    vecs[1] = '{16'h0000, 16'h0000, 8'h01, 8'h01};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h02, 8'hFE};
    vecs[3] = '{16'h8001, 16'h7F80, 8'h03, 8'h83};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 8'h04, 8'h3C};

    bus.word_valid_i = 1'b0;
    bus.word_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_word_ready", 32'(bus.word_ready_o), 32'd1);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start_o), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data_o), 32'h00);
    check("rst_frame_busy", 32'(bus.frame_busy_o), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));

    // single frames from the vector table
    for (int v = 0; v < 5; v++) begin
      push_word(vecs[v].w0);
      push_word(vecs[v].w1);
      check("start_not_yet", 32'(bus.tx_start_o), 32'd0);
      @(posedge clk); #1;
      check("start_k1", 32'(bus.tx_start_o), 32'd1);
      check("sync_k1", 32'(bus.tx_data_o), 32'(SYNC_BYTE));
      check("frame_busy_k1", 32'(bus.frame_busy_o), 32'd1);
      wait_bytes(7, "vec");
      expect_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].w0, vecs[v].w1, vecs[v].csum);
    end

    // back-to-back frames after reset
    do_reset();
    max_gap = 0;
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    push_word(16'h0708);
    wait_bytes(14, "b2b");
    expect_frame("b2b0", 8'h00, 16'h0102, 16'h0304, 8'h0A);
    expect_frame("b2b1", 8'h01, 16'h0506, 16'h0708, 8'h1B);
    check("b2b_byte_gap", 32'(max_gap), 32'd1);

    // start held while the transmitter is not yet accepting
    tx_hold = 1'b1;
    push_word(16'h5555);
    push_word(16'hAAAA);
    @(posedge clk); #1;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_start_o !== 1'b1 || bus.tx_data_o !== SYNC_BYTE) hold_bad++;
    end
    check("start_hold", 32'(hold_bad), 32'd0);
    tx_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT && !seen; i++) begin
      @(negedge clk); #1;
      seen = busy;
    end
    check("busy_seen", 32'(seen), 32'd1);
    check("start_before_sample", 32'(bus.tx_start_o), 32'd1);
    @(posedge clk); #1;
    check("start_drop", 32'(bus.tx_start_o), 32'd0);
    wait_bytes(7, "hold");
    expect_frame("hold", 8'h02, 16'h5555, 16'hAAAA, 8'h00);

    // overflow with the transmitter stalled
    tx_hold = 1'b1;
    for (int i = 0; i < 8; i++) push_word(16'(16'h1100 + i));
    check("ovf_ready_full", 32'(bus.word_ready_o), 32'd0);
    check("ovf_not_yet", 32'(bus.overflow_o), 32'd0);
    push_word(16'h11FF);
    check("ovf_set", 32'(bus.overflow_o), 32'd1);
    tx_hold = 1'b0;
    wait_bytes(28, "ovf");
    for (int f = 0; f < 4; f++) begin
      a = 16'(16'h1100 + 2 * f);
      b = 16'(16'h1101 + 2 * f);
      expect_frame($sformatf("ovf%0d", f), 8'(3 + f), a, b, calc_csum(8'(3 + f), a, b));
    end
    repeat (100) @(posedge clk);
    #1;
    check("ninth_dropped", 32'(rx_q.size()), 32'd0);
    check("ovf_sticky", 32'(bus.overflow_o), 32'd1);
    check("ovf_ready_back", 32'(bus.word_ready_o), 32'd1);

    // sequence number wrap over 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      a = {f[7:0], 8'h3C};
      b = {8'hC3, ~f[7:0]};
      push_word(a);
      push_word(b);
      wait_bytes(7, "wrap");
      expect_frame($sformatf("wrap%0d", f), f[7:0], a, b, calc_csum(f[7:0], a, b));
    end

    // reset during the third byte of a frame
    push_word(16'h7777);
    push_word(16'h8888);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT && !seen; i++) begin
      @(negedge clk);
      seen = (rx_q.size() >= 3);
    end
    check("third_byte_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_start", 32'(bus.tx_start_o), 32'd0);
    check("mid_rst_frame_busy", 32'(bus.frame_busy_o), 32'd0);
    check("mid_rst_ready", 32'(bus.word_ready_o), 32'd1);
    check("mid_rst_data", 32'(bus.tx_data_o), 32'h00);
    reset = 1'b0;
    rx_q.delete();
    repeat (40) @(posedge clk);
    #1;
    check("abandoned_no_csum", 32'(rx_q.size()), 32'd0);
    push_word(16'h1234);
    push_word(16'hABCD);
    wait_bytes(7, "post_rst");
    expect_frame("post_rst", 8'h00, 16'h1234, 16'hABCD, 8'hBE);

    check("data_stable", 32'(stab_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

- Packetiser sitting directly upstream of the UART transmitter.
- Accepts fixed-width telemetry words (position/current samples) from the actuator control core and buffers them in a small FIFO.
- Each group of N_WORDS words becomes one framed packet: sync, sequence number, payload, checksum.
- Feeds the packet byte by byte into the transmitter's start/data/busy handshake, holding each byte stable for its whole transmission.

## Interface
- WORD_W, 16: input word width; multiple of 8; sent MSB byte first.
- N_WORDS, 2: words per frame; 1..FIFO_DEPTH.
- FIFO_DEPTH, 8: word FIFO depth; power of 2, ≥ N_WORDS.
- clk_i  in  1  system clock; single clock domain.
- reset_i  in  1  reset, synchronous, active-high.
- word_valid_i  in  1  input word present.
- word_i  in  WORD_W  input word.
- word_ready_o  out  1  FIFO not full; a word is accepted when word_valid_i && word_ready_o. Reset value 1.
- overflow_o  out  1  sticky; set when word_valid_i && !word_ready_o (word dropped); cleared only by reset. Reset value 0.
- tx_start_o  out  1  byte request to transmitter. Reset value 0.
- tx_data_o  out  8  byte to transmit; stable from request until transmitter busy falls. Reset value 8'h00.
- tx_busy_i  in  1  transmitter busy.
- frame_busy_o  out  1  high from frame start until last byte's busy falls. Reset value 0.

## Operation
- Frame byte order: SYNC = 8'hA5, SEQ, then payload of N_WORDS × WORD_W/8 bytes (words in FIFO order, each MSB byte first), then CSUM.
- CSUM: 8-bit sum mod 256 of SEQ and all payload bytes; SYNC is excluded.
- SEQ: 8-bit counter, 0 after reset, +1 after each completed frame, wraps 8'hFF → 8'h00.
- FSM states: IDLE, REQ, WAIT.
- IDLE: when FIFO count ≥ N_WORDS, go to REQ with tx_data_o = SYNC and frame_busy_o = 1; clear the checksum accumulator.
- REQ: tx_start_o = 1, held until tx_busy_i is sampled 1. Then go to WAIT with tx_start_o = 0.
  - Holding start until busy is seen covers the transmitter's post-reset warm-up, during which it is not yet idle.
- WAIT: hold tx_data_o. On tx_busy_i = 0:
  - More bytes remain: load the next byte into tx_data_o on the same edge and go to REQ.
  - CSUM was the byte just sent: go to IDLE, frame_busy_o = 0, SEQ + 1.
- FIFO pop: a word is popped on the edge where its last (LSB) byte is loaded into tx_data_o.
  - The payload byte mux reads the FIFO head plus a byte index.
- FIFO push and pop in the same cycle: both take effect; count unchanged. Push when full: dropped, overflow_o set. Pop never occurs when empty.
- Checksum accumulates each SEQ/payload byte as it is loaded.

## Timing
- Frame start: FIFO count reaches N_WORDS at edge k with FSM in IDLE → tx_start_o = 1 and tx_data_o = 8'hA5 from cycle k+1.
- tx_start_o falls the cycle after tx_busy_i is first sampled high.
- Next byte and tx_start_o appear 1 cycle after tx_busy_i falls.
- word_ready_o is combinational from the registered count; it reflects a pop one cycle later.
- Reset at any time, including mid-frame:
  - FIFO flushed, FSM to IDLE, SEQ = 0, overflow_o = 0.
  - All outputs take their reset values on the next edge.
  - A partially sent frame is abandoned; no CSUM is sent.

## Structure
- Package uart_frame_pkg: SYNC_BYTE = 8'hA5, FSM state enum, byte-index width helper.
- Sub-module uart_word_fifo: synchronous FIFO with push/pop/count/full/empty, parameterised by WORD_W and FIFO_DEPTH.
- Framer FSM, byte mux, SEQ counter and checksum live in uart_tx_framer.
- Bench pairs the framer with a behavioural transmitter model: busy rises 1 cycle after an accepted start and lasts 10 bit periods.

## Test plan
- Single frame: push 16'h1234, 16'hABCD → bytes A5 00 12 34 AB CD BE, frame_busy_o drops after BE; tx_data_o is stable throughout each busy window.
- Back-to-back: push 4 words → two frames with SEQ 00 then 01, and no idle byte gap beyond 1 cycle per byte.
- Start hold: keep tx_busy_i low for 50 cycles after request → tx_start_o stays 1 and tx_data_o stays 8'hA5; first busy → start drops next cycle.
- Overflow: with transmitter stalled, push 9 words → word_ready_o = 0 after 8, overflow_o = 1, 9th word absent from output.
- SEQ wrap: send 257 frames → frame 256 carries SEQ FF, frame 257 carries SEQ 00, and CSUM is correct for both.
- Reset mid-frame: assert reset_i during the 3rd byte → tx_start_o = 0, frame_busy_o = 0, word_ready_o = 1 next cycle; next frame begins with A5 00.
